// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helper for the fifo_1 datapath buffer.
package fifo_pkg;
  localparam int FIFO_SIZE_DEF = 8;
  localparam int DATA_SIZE_DEF = 24;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/fifo_1_mem.sv
// Register array: synchronous write port, asynchronous read port.
// No reset on storage; the reader only ever addresses slots that were written.
module fifo_1_mem
  import fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_SIZE_DEF,
  parameter int WIDTH = DATA_SIZE_DEF,
  parameter int AW    = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];
endmodule

// File: rtl/fifo_1.sv
// Single-clock FIFO with registered read data; the popped word is visible right after the accepting edge.
// Writes on full are dropped unless a read frees a slot on the same edge; reads on empty are ignored (no bypass).
module fifo_1
  import fifo_pkg::*;
#(
  parameter int FIFO_SIZE = FIFO_SIZE_DEF,
  parameter int DATA_SIZE = DATA_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_en,
  input  logic                 wr_en,
  input  logic [DATA_SIZE-1:0] input_data,
  output logic                 empty,
  output logic                 full,
  output logic [DATA_SIZE-1:0] output_data
);
  localparam int PW = ptr_w(FIFO_SIZE);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [DATA_SIZE-1:0] out_q, out_d;
  logic [DATA_SIZE-1:0] head_dat;
  logic                 rd_accept;
  logic                 wr_accept;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(FIFO_SIZE));

  // A read on full frees the head slot, so the write may land in the same edge.
  assign rd_accept = rd_en && !empty;
  assign wr_accept = wr_en && (!full || rd_accept);

  fifo_1_mem #(
    .DEPTH (FIFO_SIZE),
    .WIDTH (DATA_SIZE),
    .AW    (PW)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (wr_accept),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (input_data),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (head_dat)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    out_d    = out_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      out_d    = head_dat;
    end
    if (wr_accept && !rd_accept) begin
      count_d = count_q + CNT_ONE;
    end else if (rd_accept && !wr_accept) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      out_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      out_q    <= out_d;
    end
  end

  assign output_data = out_q;
endmodule

// File: tb/tb_fifo_1.sv
// Bench for fifo_1: directed scenarios then randomized traffic against a queue-based reference.
module tb_fifo_1;
  localparam int DEPTH = 8;
  localparam int W     = 24;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd_en;
  logic         wr_en;
  logic [W-1:0] input_data;
  logic         empty;
  logic         full;
  logic [W-1:0] output_data;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] ref_q [$];
  logic [W-1:0] ref_out;

  fifo_1 #(.FIFO_SIZE(DEPTH), .DATA_SIZE(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_en       (rd_en),
    .wr_en       (wr_en),
    .input_data  (input_data),
    .empty       (empty),
    .full        (full),
    .output_data (output_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".out"},   32'(output_data), 32'(ref_out));
    chk({tag, ".empty"}, 32'(empty), 32'(ref_q.size() == 0));
    chk({tag, ".full"},  32'(full),  32'(ref_q.size() == DEPTH));
  endtask

  // One clock: drive, let the edge happen, advance the reference, compare.
  task automatic cycle(input logic r, input logic w, input logic [W-1:0] d, input string tag);
    bit rd_ok, wr_ok;
    rd_en = r;
    wr_en = w;
    input_data = d;
    @(posedge clk);
    rd_ok = r && (ref_q.size() != 0);
    wr_ok = w && ((ref_q.size() < DEPTH) || rd_ok);
    if (rd_ok) ref_out = ref_q.pop_front();
    if (wr_ok) ref_q.push_back(d);
    #1;
    chk_state(tag);
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic async_reset(input string tag);
    rst = 1'b1;
    ref_q.delete();
    ref_out = '0;
    #1;
    chk({tag, ".empty"}, 32'(empty), 32'd1);
    chk({tag, ".full"},  32'(full),  32'd0);
    chk({tag, ".out"},   32'(output_data), 32'd0);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rd_en = 1'b0;
    wr_en = 1'b0;
    input_data = '0;
    ref_out = '0;
    #1;
    chk("reset.empty", 32'(empty), 32'd1);
    chk("reset.full",  32'(full),  32'd0);
    chk("reset.out",   32'(output_data), 32'd0);
    #11;
    rst = 1'b0;

    // Fill to full.
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, W'(100 + i), "fill");
    chk("fill.full_const", 32'(full), 32'd1);
    chk("fill.out_const",  32'(output_data), 32'd0);

    // Simultaneous read+write while full.
    cycle(1'b1, 1'b1, W'(150), "full_rw");
    chk("full_rw.out_const", 32'(output_data), 32'd100);
    chk("full_rw.full_const", 32'(full), 32'd1);

    // Drain, then read on empty.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, '0, "drain");
    chk("drain.last_const", 32'(output_data), 32'd150);
    cycle(1'b1, 1'b0, '0, "rd_empty");
    chk("rd_empty.hold_const", 32'(output_data), 32'd150);

    // Simultaneous read+write while empty: no bypass.
    cycle(1'b1, 1'b1, W'(170), "empty_rw");
    chk("empty_rw.hold_const", 32'(output_data), 32'd150);
    chk("empty_rw.empty_const", 32'(empty), 32'd0);

    // Alternating write/read.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, W'(200 + i), "alt_wr");
      cycle(1'b1, 1'b0, '0, "alt_rd");
    end
    chk("alt.last_const", 32'(output_data), 32'd201);

    cycle(1'b0, 1'b1, W'(150), "mix_wr0");
    cycle(1'b0, 1'b1, W'(151), "mix_wr1");
    cycle(1'b1, 1'b1, W'(152), "mix_rw");
    chk("mix_rw.out_const", 32'(output_data), 32'd202);
    cycle(1'b1, 1'b0, '0, "mix_rd0");
    cycle(1'b1, 1'b0, '0, "mix_rd1");
    chk("mix_rd1.out_const", 32'(output_data), 32'd151);

    // Reset mid-sequence with data still queued.
    cycle(1'b0, 1'b1, W'(300), "pre_rst");
    async_reset("mid_rst");
    cycle(1'b1, 1'b0, '0, "post_rst_rd");

    // Randomized traffic with phases biased toward filling or draining.
    for (int n = 0; n < 3000; n++) begin
      int rp, wp;
      logic r, w;
      if ((n / 100) % 3 == 0) begin rp = 20; wp = 80; end
      else if ((n / 100) % 3 == 1) begin rp = 80; wp = 20; end
      else begin rp = 50; wp = 50; end
      r = ($urandom_range(0, 99) < rp);
      w = ($urandom_range(0, 99) < wp);
      if ($urandom_range(0, 499) == 0) async_reset("rand_rst");
      cycle(r, w, W'($urandom), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_1.md
Name: fifo_1

Overview:
- Synchronous single-clock first-in-first-out buffer of FIFO_SIZE words, each DATA_SIZE bits wide.
- It decouples a producer and a consumer running in the same clock domain inside the accelerator datapath.
- It provides full and empty status flags and a registered read-data output.

Parameters:
- FIFO_SIZE, 8, depth in words; must be a power of two and at least 2.
- DATA_SIZE, 24, word width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- rd_en  input  1  read request; pops the head word on a rising edge when accepted.
- wr_en  input  1  write request; pushes input_data on a rising edge when accepted.
- input_data  input  DATA_SIZE  word to write.
- empty  output  1  high when the occupancy is 0.
- full  output  1  high when the occupancy equals FIFO_SIZE.
- output_data  output  DATA_SIZE  registered read data: the last word popped.

Behaviour:
- Reset (rst=1, asynchronous): read pointer, write pointer and count go to 0; output_data=0; empty=1; full=0. Storage contents are don't-care.
- Releasing reset takes effect at the next rising clk edge.
- State: storage array of FIFO_SIZE x DATA_SIZE, wr_ptr and rd_ptr of log2(FIFO_SIZE) bits, count of log2(FIFO_SIZE)+1 bits.
- empty = (count==0) and full = (count==FIFO_SIZE). Both are combinational from count, with no extra latency.
- Write accepted when wr_en && (!full || rd_accept):
  - mem[wr_ptr] <= input_data.
  - wr_ptr increments modulo FIFO_SIZE (natural wrap).
- Read accepted (rd_accept) when rd_en && !empty:
  - output_data <= mem[rd_ptr].
  - rd_ptr increments modulo FIFO_SIZE.
- Read latency: output_data updates on the same rising edge that accepts the read, so the popped word is visible after that edge.
- output_data holds its value when no read is accepted.
- Count update:
  - +1 on a write-only accept.
  - -1 on a read-only accept.
  - Unchanged on both or neither.
- Simultaneous rd_en and wr_en when full:
  - Both are accepted; the head word is output and the new word is stored in the freed slot.
  - count stays FIFO_SIZE and full stays 1.
- Simultaneous rd_en and wr_en when empty:
  - The write is accepted and the read is ignored. There is no bypass.
  - output_data holds; count becomes 1; empty drops.
- Simultaneous rd_en and wr_en otherwise: both are accepted and count is unchanged.
- Write when full without a read: ignored silently; no storage or pointer change.
- Read when empty without a write: ignored silently; output_data holds.
- Reset mid-operation: all contents are discarded immediately; flags return to empty=1, full=0.
- There are no X-propagation paths from unwritten storage to output_data.

Decomposition:
- Shared package fifo_pkg holds FIFO_SIZE and DATA_SIZE defaults and a helper constant for the pointer width (clog2 of depth).
- One natural sub-module: fifo_1_mem, a simple dual-port register array with a synchronous write port and an asynchronous read port indexed by pointer.
- Pointer/count control and the output register stay in fifo_1.

Test Plan:
1. Reset, then write 100..107 on 8 consecutive cycles -> empty drops after the first write; full=1 after the 8th; output_data stays 0.
2. While full, rd_en=wr_en=1 with input_data=150 for one cycle -> output_data=100; full remains 1; count stays 8.
3. Read 8 times -> output_data sequence 101,102,...,107,150; empty=1 after the last read. A further read leaves output_data=150.
4. While empty, rd_en=wr_en=1 with input_data=170 -> output_data stays 150; empty=0; count=1.
5. Alternate write 200/read, write 201/read, write 202/read -> reads return 170, 200, 201; 202 remains in the FIFO.
6. Write 150, write 151, then write 152 with a simultaneous read, then two reads -> reads return 202, 150, 151. Also assert rst mid-sequence -> empty=1, full=0 and output_data=0 immediately, without waiting for a clock edge.
